sext_rr_sched: RTL
==================

# sext_rr_sched

Round-robin scheduler that shares one 8-to-32-bit extension datapath among `NREQ` byte-producing requesters. Each requester offers a byte and an extend mode over a val/rdy handshake. The block grants one requester per cycle and extends the byte by sign or zero. It drives a registered 32-bit result, tagged with the requester index, onto a single val/rdy output stream. It sits between the byte-load return path and the writeback stage.

## Interface
- `NREQ`, 4: number of requesters, 2..8.
- `IDW`, `$clog2(NREQ)`: requester-index width.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `req_val` in NREQ: per-requester valid.
- `req_rdy` out NREQ: per-requester ready, one-hot or zero.
- `req_in_` in NREQ×8: per-requester byte, packed, requester i at bits [8i+7:8i].
- `req_sext` in NREQ: per-requester mode; 1 = sign-extend, 0 = zero-extend.
- `out_val` out 1: result valid.
- `out_rdy` in 1: downstream ready.
- `out` out 32: extended result.
- `out_id` out IDW: index of the requester that produced `out`.

## Operation
- The output register is a one-entry buffer holding `out`, `out_id` and `out_val`.
- `can_accept = !out_val || out_rdy`.
- Grant rule: when `can_accept` is high, grant the first requester with `req_val` high, searching circularly from `ptr`.
  - `req_rdy` is high only for the granted index.
  - `req_rdy` is all-zero when `can_accept` is low or no requester is valid.
  - `req_rdy` never depends on `req_val` of other grantees beyond the arbitration search, so there is no combinational loop through `out_rdy` → `req_rdy`.
- Transfer occurs when `req_val[g] && req_rdy[g]`. On transfer, the output register loads:
  - `out` = `{ {24{req_in_[g][7] & req_sext[g]}}, req_in_[g] }`
  - `out_id` = g
  - `out_val` = 1
  - `ptr` = (g+1) mod NREQ
- Dequeue without a new transfer (`out_val && out_rdy`, no grant): clear `out_val`; `out` and `out_id` hold their last values.
- Simultaneous dequeue and transfer: the register reloads with the new result and `out_val` stays 1, giving full throughput of one result per cycle.
- Stall (`out_val && !out_rdy`): `out`, `out_id` and `out_val` hold stable and `req_rdy` is 0.
- `ptr` changes only on transfer. It wraps from NREQ-1 to 0.
- Reset mid-operation discards the buffered result immediately. No partial handshake is completed.

## Timing
- Reset values: `out_val`=0, `out`=0, `out_id`=0, `ptr`=0.
- `req_rdy` is forced to 0 while `reset` is high.
- Latency: a byte accepted at edge N appears on `out` with `out_val`=1 after edge N, visible in cycle N+1.
- Throughput: one result per cycle when `out_rdy` is held high.
- Fairness: any continuously valid requester is granted within NREQ transfers.
- `req_rdy` is combinational from `req_val`, `ptr`, `out_val` and `out_rdy`. All other outputs come directly from flops.

## Structure
- Package `sext_sched_pkg`:
  - `localparam` default `NREQ`.
  - function `sext8to32(logic [7:0] b, logic s)` returning `logic [31:0]`.
  - typedef `sext_resp_t` as a packed struct `{ logic [31:0] data; logic [IDW-1:0] id; }`.
- Sub-module `rr_arb`, parameterized by N:
  - Inputs: `req` [N], `en`, `ptr` [IDW].
  - Outputs: `gnt` one-hot [N], `gnt_idx` [IDW].
  - Purely combinational.
  - The pointer flop stays in the top level, so the arbiter is reusable elsewhere in the codebase.
- Top level holds `ptr`, the output register and the extension function call.

## Test plan
- **Reset, then one request.** `req_val`=4'b0001, `req_in_[0]`=8'h80, `req_sext[0]`=1, `out_rdy`=1 → next cycle `out`=32'hFFFF_FF80, `out_id`=0, `out_val`=1. Repeat with `req_sext[0]`=0 → `out`=32'h0000_0080.
- **Rotation.** All four requesters valid every cycle with bytes 8'h01..8'h04, `out_rdy`=1 → `out_id` sequence 0,1,2,3,0,…; one result per cycle; each `req_rdy` pulses once per 4 cycles.
- **Backpressure.** `out_rdy`=0 with one buffered result (8'h7F, sext) → `out`=32'h0000_007F held stable and `req_rdy`=0 for 5 cycles. Raise `out_rdy` → dequeue and a new grant in the same cycle; `out_val` stays 1.
- **Pointer wrap and skip.** `ptr`=3, only requesters 1 and 3 valid → grant 3, then 1. Requester 0 is idle and never granted; `ptr` goes 0 then 2.
- **Mid-stream reset.** Assert `reset` asynchronously mid-cycle while `out_val`=1 → `out_val`, `out`, `out_id` go 0 immediately. After release, the first grant goes to the lowest valid index because `ptr`=0.
- **Idle drain.** Single result, then `req_val`=0 and `out_rdy`=1 → `out_val` drops the next cycle, `out` holds its value, `ptr` is unchanged.

Source files
------------

// File: rtl/sext_sched_pkg.sv
// Shared types and helpers for the byte sign/zero-extension scheduler.
package sext_sched_pkg;

    localparam int unsigned SEXT_NREQ = 4;
    // Id field sized for the largest supported requester count (8).
    localparam int unsigned SEXT_ID_W = 3;

    typedef struct packed {
        logic [31:0]          data;
        logic [SEXT_ID_W-1:0] id;
    } sext_resp_t;

    function automatic logic [31:0] sext8to32(logic [7:0] b, logic s);
        return {{24{b[7] & s}}, b};
    endfunction

endpackage

// File: rtl/rr_arb.sv
// Combinational round-robin arbiter; the priority pointer lives in the caller.
module rr_arb #(
    parameter int unsigned N   = 4,
    parameter int unsigned IDW = $clog2(N)
) (
    input  logic [N-1:0]   req,
    input  logic           en,
    input  logic [IDW-1:0] ptr,
    output logic [N-1:0]   gnt,
    output logic [IDW-1:0] gnt_idx
);

    logic found;

    // First requester at or after ptr, wrapping circularly.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            int unsigned k;
            k = 32'(ptr) + i;
            if (k >= N) k = k - N;
            if (en && !found && req[IDW'(k)]) begin
                found          = 1'b1;
                gnt[IDW'(k)]   = 1'b1;
                gnt_idx        = IDW'(k);
            end
        end
    end

endmodule

// File: rtl/sext_rr_sched.sv
// Round-robin share of one 8-to-32 extension datapath with a one-entry output buffer.
module sext_rr_sched
    import sext_sched_pkg::*;
#(
    parameter int unsigned NREQ = SEXT_NREQ,
    parameter int unsigned IDW  = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NREQ-1:0]   req_val,
    output logic [NREQ-1:0]   req_rdy,
    input  logic [NREQ*8-1:0] req_in_,
    input  logic [NREQ-1:0]   req_sext,
    output logic              out_val,
    input  logic              out_rdy,
    output logic [31:0]       out,
    output logic [IDW-1:0]    out_id
);

    sext_resp_t     resp_q, resp_d;
    logic           out_val_q, out_val_d;
    logic [IDW-1:0] ptr_q, ptr_d;

    logic           can_accept_c;
    logic [NREQ-1:0] gnt;
    logic [IDW-1:0] gnt_idx;
    logic           xfer_c;
    logic [7:0]     sel_byte_c;
    logic           sel_sext_c;

    assign can_accept_c = !out_val_q || out_rdy;

    rr_arb #(.N(NREQ), .IDW(IDW)) u_arb (
        .req     (req_val),
        .en      (can_accept_c && !reset),
        .ptr     (ptr_q),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    assign req_rdy = gnt;
    assign xfer_c  = |(req_val & gnt);

    // One-hot mux of the granted requester's byte and mode.
    always_comb begin
        sel_byte_c = '0;
        sel_sext_c = 1'b0;
        for (int i = 0; i < int'(NREQ); i++) begin
            if (gnt[i]) begin
                sel_byte_c = req_in_[8*i +: 8];
                sel_sext_c = req_sext[i];
            end
        end
    end

    always_comb begin
        resp_d    = resp_q;
        out_val_d = out_val_q;
        ptr_d     = ptr_q;
        if (xfer_c) begin
            resp_d.data = sext8to32(sel_byte_c, sel_sext_c);
            resp_d.id   = SEXT_ID_W'(gnt_idx);
            out_val_d   = 1'b1;
            ptr_d       = (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + IDW'(1);
        end else if (out_val_q && out_rdy) begin
            out_val_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            resp_q    <= '0;
            out_val_q <= 1'b0;
            ptr_q     <= '0;
        end else begin
            resp_q    <= resp_d;
            out_val_q <= out_val_d;
            ptr_q     <= ptr_d;
        end
    end

    assign out     = resp_q.data;
    assign out_id  = resp_q.id[IDW-1:0];
    assign out_val = out_val_q;

endmodule
